// File: rtl/dr_addsub_sync.sv
// Clocked dual-rail adder/subtractor: four-phase RTZ operand link in, segmented
// carry-chain compute, DEPTH-entry result buffer, four-phase RTZ result link out.
module dr_addsub_sync #(
   parameter  int WIDTH    = 8,
   parameter  int SEGS     = 2,
   parameter  int DEPTH    = 2,
   localparam int RAIL_NUM = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   output logic                               ack_o,
   input  logic [WIDTH-1:0][RAIL_NUM-1:0]     a,
   input  logic [WIDTH-1:0][RAIL_NUM-1:0]     b,
   input  logic [RAIL_NUM-1:0]                c_in,
   input  logic [RAIL_NUM-1:0]                sub,
   input  logic                               ack_i,
   output logic [WIDTH-1:0][RAIL_NUM-1:0]     s,
   output logic [RAIL_NUM-1:0]                c_out,
   output logic [RAIL_NUM-1:0]                ovf,
   output logic                               err
);

   localparam int SEG_W  = WIDTH / SEGS;
   localparam int SIDX_W = (SEGS > 1) ? $clog2(SEGS) : 1;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam logic [SIDX_W-1:0] LAST_SEG = SIDX_W'(SEGS - 1);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);

   typedef enum logic       {IN_IDLE, IN_ACK} in_state_t;
   typedef enum logic [1:0] {OUT_SPACER, OUT_DATA, OUT_RTZ} out_state_t;

   function automatic logic [WIDTH-1:0][RAIL_NUM-1:0] dr_enc(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0][RAIL_NUM-1:0] r;
      for (int i = 0; i < WIDTH; i++) r[i] = {v[i], ~v[i]};
      return r;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   in_state_t                r_in_state;
   out_state_t               r_out_state;
   logic                     r_ack;
   logic                     r_err;
   logic                     r_busy;
   logic [SIDX_W-1:0]        r_seg_idx;
   logic [WIDTH-1:0]         r_a;
   logic [WIDTH-1:0]         r_b;
   logic [WIDTH-1:0]         r_sum;
   logic                     r_carry;
   logic [WIDTH-1:0]         r_buf_s [DEPTH];
   logic                     r_buf_c [DEPTH];
   logic                     r_buf_o [DEPTH];
   logic [PTR_W-1:0]         r_wr_ptr;
   logic [PTR_W-1:0]         r_rd_ptr;
   logic [CNT_W-1:0]         r_count;
   logic [WIDTH-1:0][RAIL_NUM-1:0] r_s;
   logic [RAIL_NUM-1:0]      r_c_out;
   logic [RAIL_NUM-1:0]      r_ovf;

   logic                     w_complete;
   logic                     w_empty;
   logic                     w_illegal;
   logic [WIDTH-1:0]         w_a_bits;
   logic [WIDTH-1:0]         w_b_bits;
   logic                     w_accept;
   logic                     w_push;
   logic                     w_pop;
   int                       w_base;
   logic [SEG_W:0]           w_seg_sum;
   logic [WIDTH-1:0]         w_full_sum;
   logic                     w_ovf;

   // Input link decode: completion, spacer and illegal-code detection
   always_comb begin
      w_complete = (c_in[1] ^ c_in[0]) & (sub[1] ^ sub[0]);
      w_empty    = ~|c_in & ~|sub;
      w_illegal  = (&c_in) | (&sub);
      for (int i = 0; i < WIDTH; i++) begin
         w_a_bits[i] = a[i][1];
         w_b_bits[i] = b[i][1];
         w_complete  = w_complete & (a[i][1] ^ a[i][0]) & (b[i][1] ^ b[i][0]);
         w_empty     = w_empty & ~|a[i] & ~|b[i];
         w_illegal   = w_illegal | (&a[i]) | (&b[i]);
      end
   end

   // Engine idle implies nothing in flight, so the count alone decides the free slot
   assign w_accept = (r_in_state == IN_IDLE) && w_complete && !r_busy && (r_count < DEPTH_C);
   assign w_push   = r_busy && (r_seg_idx == LAST_SEG);
   assign w_pop    = (r_out_state == OUT_DATA) && ack_i;

   // One carry-chain slice per cycle; overflow from carry into vs out of the MSB
   always_comb begin
      w_base     = int'(r_seg_idx) * SEG_W;
      w_seg_sum  = {1'b0, r_a[w_base +: SEG_W]} + {1'b0, r_b[w_base +: SEG_W]}
                 + {{SEG_W{1'b0}}, r_carry};
      w_full_sum = r_sum;
      w_full_sum[w_base +: SEG_W] = w_seg_sum[SEG_W-1:0];
      w_ovf      = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_full_sum[WIDTH-1] ^ w_seg_sum[SEG_W];
   end

   // Input handshake FSM
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_in_state <= IN_IDLE;
         r_ack      <= 1'b0;
      end else begin
         case (r_in_state)
            IN_IDLE: if (w_accept) begin
               r_in_state <= IN_ACK;
               r_ack      <= 1'b1;
            end
            IN_ACK: if (w_empty) begin
               r_in_state <= IN_IDLE;
               r_ack      <= 1'b0;
            end
            default: begin
               r_in_state <= IN_IDLE;
               r_ack      <= 1'b0;
            end
         endcase
      end
   end

   // Operand latch and segment sequencer
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_busy    <= 1'b0;
         r_seg_idx <= {SIDX_W{1'b0}};
         r_a       <= {WIDTH{1'b0}};
         r_b       <= {WIDTH{1'b0}};
         r_sum     <= {WIDTH{1'b0}};
         r_carry   <= 1'b0;
      end else if (w_accept) begin
         r_busy    <= 1'b1;
         r_seg_idx <= {SIDX_W{1'b0}};
         r_a       <= w_a_bits;
         r_b       <= w_b_bits ^ {WIDTH{sub[1]}};
         r_sum     <= {WIDTH{1'b0}};
         r_carry   <= c_in[1] ^ sub[1];
      end else if (r_busy) begin
         r_sum   <= w_full_sum;
         r_carry <= w_seg_sum[SEG_W];
         if (r_seg_idx == LAST_SEG) begin
            r_busy    <= 1'b0;
            r_seg_idx <= {SIDX_W{1'b0}};
         end else begin
            r_seg_idx <= r_seg_idx + SIDX_W'(1);
         end
      end
   end

   // Result buffer
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            r_buf_s[i] <= {WIDTH{1'b0}};
            r_buf_c[i] <= 1'b0;
            r_buf_o[i] <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_buf_s[r_wr_ptr] <= w_full_sum;
            r_buf_c[r_wr_ptr] <= w_seg_sum[SEG_W];
            r_buf_o[r_wr_ptr] <= w_ovf;
            r_wr_ptr          <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
   end

   // Output handshake FSM with registered dual-rail outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_out_state <= OUT_SPACER;
         r_s         <= {(WIDTH*RAIL_NUM){1'b0}};
         r_c_out     <= 2'b00;
         r_ovf       <= 2'b00;
      end else begin
         case (r_out_state)
            OUT_SPACER: if ((r_count != {CNT_W{1'b0}}) && !ack_i) begin
               r_out_state <= OUT_DATA;
               r_s         <= dr_enc(r_buf_s[r_rd_ptr]);
               r_c_out     <= {r_buf_c[r_rd_ptr], ~r_buf_c[r_rd_ptr]};
               r_ovf       <= {r_buf_o[r_rd_ptr], ~r_buf_o[r_rd_ptr]};
            end
            OUT_DATA: if (ack_i) begin
               r_out_state <= OUT_RTZ;
               r_s         <= {(WIDTH*RAIL_NUM){1'b0}};
               r_c_out     <= 2'b00;
               r_ovf       <= 2'b00;
            end
            OUT_RTZ: if (!ack_i) r_out_state <= OUT_SPACER;
            default: begin
               r_out_state <= OUT_SPACER;
               r_s         <= {(WIDTH*RAIL_NUM){1'b0}};
               r_c_out     <= 2'b00;
               r_ovf       <= 2'b00;
            end
         endcase
      end
   end

   // Sticky illegal-code flag
   always_ff @(posedge clk) begin
      if (!rst)           r_err <= 1'b0;
      else if (w_illegal) r_err <= 1'b1;
   end

   assign ack_o = r_ack;
   assign s     = r_s;
   assign c_out = r_c_out;
   assign ovf   = r_ovf;
   assign err   = r_err;

endmodule

// File: tb/tb_dr_addsub_sync.sv
// Directed self-checking bench for dr_addsub_sync (WIDTH=8, SEGS=2, DEPTH=2).
module tb_dr_addsub_sync;

   logic             clk = 1'b0;
   logic             rst;
   logic             ack_o;
   logic [7:0][1:0]  a, b;
   logic [1:0]       c_in, sub;
   logic             ack_i;
   logic [7:0][1:0]  s;
   logic [1:0]       c_out, ovf;
   logic             err;

   int n_cmp  = 0;
   int n_fail = 0;

   dr_addsub_sync dut (
      .clk(clk), .rst(rst), .ack_o(ack_o), .a(a), .b(b), .c_in(c_in), .sub(sub),
      .ack_i(ack_i), .s(s), .c_out(c_out), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0][1:0] enc8(input logic [7:0] v);
      logic [7:0][1:0] r;
      for (int i = 0; i < 8; i++) r[i] = {v[i], ~v[i]};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive_token(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv);
      a = enc8(av); b = enc8(bv); c_in = {cv, ~cv}; sub = {sv, ~sv};
   endtask

   task automatic drive_spacer();
      a = '0; b = '0; c_in = 2'b00; sub = 2'b00;
   endtask

   task automatic wait_ack(input logic level, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         if (ack_o === level) ok = 1'b1;
         else tick();
      end
   endtask

   task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv, output bit ok);
      bit ok1, ok2;
      drive_token(av, bv, cv, sv);
      wait_ack(1'b1, ok1);
      drive_spacer();
      wait_ack(1'b0, ok2);
      ok = ok1 & ok2;
   endtask

   task automatic wait_data(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         if (s[0] !== 2'b00) ok = 1'b1;
         else tick();
      end
   endtask

   task automatic pop();
      ack_i = 1'b1; tick();
      ack_i = 1'b0; tick();
   endtask

   task automatic test_reset();
      rst = 1'b0; ack_i = 1'b0; drive_spacer();
      tick(); tick();
      rst = 1'b1;
      tick();
      n_cmp++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack_o); end
      n_cmp++; if (s !== enc8(8'h00) && s !== 16'h0000) begin n_fail++; $display("FAIL reset_s: got %h want 0000", s); end
      n_cmp++; if (s !== 16'h0000) begin n_fail++; $display("FAIL reset_s_spacer: got %h want 0000", s); end
      n_cmp++; if (c_out !== 2'b00 || ovf !== 2'b00) begin n_fail++; $display("FAIL reset_cout_ovf: got %b/%b want 00/00", c_out, ovf); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
   endtask

   task automatic test_add_latency();
      drive_token(8'h3C, 8'h05, 1'b0, 1'b0);
      tick();
      n_cmp++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL add_ack_rise: got %b want 1", ack_o); end
      drive_spacer();
      tick();
      n_cmp++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL add_ack_fall: got %b want 0", ack_o); end
      n_cmp++; if (s !== 16'h0000) begin n_fail++; $display("FAIL add_early_s2: got %h want 0000", s); end
      tick();
      n_cmp++; if (s !== 16'h0000) begin n_fail++; $display("FAIL add_early_s3: got %h want 0000", s); end
      tick();
      n_cmp++; if (s !== enc8(8'h41)) begin n_fail++; $display("FAIL add_s: got %h want %h", s, enc8(8'h41)); end
      n_cmp++; if (c_out !== 2'b01 || ovf !== 2'b01) begin n_fail++; $display("FAIL add_cout_ovf: got %b/%b want 01/01", c_out, ovf); end
      ack_i = 1'b1; tick();
      n_cmp++; if (s !== 16'h0000 || c_out !== 2'b00) begin n_fail++; $display("FAIL add_rtz: got %h/%b want 0000/00", s, c_out); end
      ack_i = 1'b0; tick();
   endtask

   task automatic test_sub_overflow();
      bit ok;
      send(8'h80, 8'h01, 1'b0, 1'b1, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL sub_handshake: got timeout want ack"); end
      wait_data(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL sub_wait: got timeout want data"); end
      n_cmp++; if (s !== enc8(8'h7F)) begin n_fail++; $display("FAIL sub_s: got %h want %h", s, enc8(8'h7F)); end
      n_cmp++; if (c_out !== 2'b10 || ovf !== 2'b10) begin n_fail++; $display("FAIL sub_cout_ovf: got %b/%b want 10/10", c_out, ovf); end
      pop();
   endtask

   task automatic test_carry_ripple();
      bit ok;
      send(8'hFF, 8'h00, 1'b1, 1'b0, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL ripple_handshake: got timeout want ack"); end
      wait_data(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL ripple_wait: got timeout want data"); end
      n_cmp++; if (s !== enc8(8'h00)) begin n_fail++; $display("FAIL ripple_s: got %h want %h", s, enc8(8'h00)); end
      n_cmp++; if (c_out !== 2'b10 || ovf !== 2'b01) begin n_fail++; $display("FAIL ripple_cout_ovf: got %b/%b want 10/01", c_out, ovf); end
      pop();
   endtask

   task automatic test_backpressure();
      bit ok1, ok2, ok;
      bit stalled;
      ack_i = 1'b0;
      send(8'h01, 8'h01, 1'b0, 1'b0, ok1);
      send(8'h02, 8'h02, 1'b0, 1'b0, ok2);
      n_cmp++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL bp_first_two: got %b%b want 11", ok1, ok2); end
      drive_token(8'h03, 8'h03, 1'b0, 1'b0);
      stalled = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (ack_o !== 1'b0) stalled = 1'b0;
         tick();
      end
      n_cmp++; if (!stalled) begin n_fail++; $display("FAIL bp_third_stall: got ack want no ack"); end
      n_cmp++; if (s !== enc8(8'h02)) begin n_fail++; $display("FAIL bp_s0: got %h want %h", s, enc8(8'h02)); end
      ack_i = 1'b1;
      wait_ack(1'b1, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_third_accept: got timeout want ack"); end
      drive_spacer();
      wait_ack(1'b0, ok);
      ack_i = 1'b0;
      wait_data(ok);
      n_cmp++; if (s !== enc8(8'h04)) begin n_fail++; $display("FAIL bp_s1: got %h want %h", s, enc8(8'h04)); end
      pop();
      wait_data(ok);
      n_cmp++; if (s !== enc8(8'h06)) begin n_fail++; $display("FAIL bp_s2: got %h want %h", s, enc8(8'h06)); end
      pop();
   endtask

   task automatic test_illegal();
      bit ok;
      drive_token(8'h10, 8'h08, 1'b0, 1'b0);
      b[3] = 2'b11;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL illegal_no_ack: got %b want 0", ack_o); end
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b want 1", err); end
      b[3] = 2'b10;
      tick();
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky: got %b want 1", err); end
      wait_ack(1'b1, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL illegal_recover_ack: got timeout want ack"); end
      drive_spacer();
      wait_ack(1'b0, ok);
      wait_data(ok);
      n_cmp++; if (s !== enc8(8'h18)) begin n_fail++; $display("FAIL illegal_recover_s: got %h want %h", s, enc8(8'h18)); end
      pop();
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      bit quiet;
      send(8'h11, 8'h22, 1'b0, 1'b0, ok);
      wait_data(ok);
      n_cmp++; if (s !== enc8(8'h33)) begin n_fail++; $display("FAIL rmid_buffered: got %h want %h", s, enc8(8'h33)); end
      drive_token(8'h05, 8'h06, 1'b0, 1'b0);
      tick();
      n_cmp++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ack: got %b want 1", ack_o); end
      tick();
      rst = 1'b0; drive_spacer();
      tick();
      n_cmp++; if (s !== 16'h0000) begin n_fail++; $display("FAIL rmid_s: got %h want 0000", s); end
      n_cmp++; if (c_out !== 2'b00 || ovf !== 2'b00) begin n_fail++; $display("FAIL rmid_cout_ovf: got %b/%b want 00/00", c_out, ovf); end
      n_cmp++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ack_clr: got %b want 0", ack_o); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b want 0", err); end
      rst = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (s !== 16'h0000) quiet = 1'b0;
      end
      n_cmp++; if (!quiet) begin n_fail++; $display("FAIL rmid_discard: got data want spacer"); end
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_sub_overflow();
      test_carry_ripple();
      test_backpressure();
      test_illegal();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion want finish");
      $fatal(1, "timeout");
   end

endmodule
